// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller: funct3 codes,
// trap causes, FSM state encoding and request decode helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WRITE,
    ST_RESP
  } lsu_state_e;

  // Stores only support the signed codes; loads also allow BU/HU.
  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!we) begin
      ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    end
    return ok;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
    logic mis;
    mis = 1'b0;
    if ((f3 == F3_H) || (f3 == F3_HU)) begin
      mis = lane[0];
    end else if (f3 == F3_W) begin
      mis = (lane != 2'b00);
    end
    return mis;
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Bundle of the core request/response handshake and the data-memory port.
// The slave modport is the controller's view, master is the core/memory side.
interface lsu_ctrl_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_adr;
  logic [31:0] req_wdata;

  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_trap;
  logic [3:0]  rsp_cause;
  logic [31:0] rsp_tval;

  logic        mem_mrd;
  logic        mem_mwr;
  logic [31:0] mem_adr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  modport slave (
    input  req_valid, req_we, req_funct3, req_adr, req_wdata, mem_dout,
    output req_ready, rsp_valid, rsp_rdata, rsp_trap, rsp_cause, rsp_tval,
    output mem_mrd, mem_mwr, mem_adr, mem_din
  );

  modport master (
    output req_valid, req_we, req_funct3, req_adr, req_wdata, mem_dout,
    input  req_ready, rsp_valid, rsp_rdata, rsp_trap, rsp_cause, rsp_tval,
    input  mem_mrd, mem_mwr, mem_adr, mem_din
  );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering between a memory word and the core: load extraction
// with sign/zero extension, and the merge step of sub-word stores.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [31:0] merged_o
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] laneMask;
  logic [31:0] laneData;

  assign shamt   = {lane_i, 3'b000};
  assign shifted = word_i >> shamt;

  always_comb begin
    rdata_o = '0;
    case (funct3_i)
      F3_B:    rdata_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    rdata_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    rdata_o = word_i;
      F3_BU:   rdata_o = {24'b0, shifted[7:0]};
      F3_HU:   rdata_o = {16'b0, shifted[15:0]};
      default: rdata_o = '0;
    endcase
  end

  // Memory has no byte enables, so the untouched lanes come from the old word.
  always_comb begin
    laneMask = '0;
    laneData = '0;
    case (funct3_i)
      F3_B: begin
        laneMask = 32'h0000_00FF << shamt;
        laneData = {24'b0, wdata_i[7:0]} << shamt;
      end
      F3_H: begin
        laneMask = 32'h0000_FFFF << shamt;
        laneData = {16'b0, wdata_i[15:0]} << shamt;
      end
      F3_W: begin
        laneMask = '1;
        laneData = wdata_i;
      end
      default: begin
        laneMask = '0;
        laneData = '0;
      end
    endcase
    merged_o = (word_i & ~laneMask) | laneData;
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller between the RV32I memory stage and a word-wide data
// memory: decode, alignment/range traps, load extension and RMW sub-word stores.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 65536
) (
  input logic       clk,
  input logic       rst,
  lsu_ctrl_if.slave bus
);

  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  lsu_state_e  state_q, state_d;

  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] adr_q;
  logic [31:0] wdata_q;

  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_trap_q, rsp_trap_d;
  logic [3:0]  rsp_cause_q, rsp_cause_d;
  logic [31:0] rsp_tval_q, rsp_tval_d;
  logic        mem_mrd_q, mem_mrd_d;
  logic        mem_mwr_q, mem_mwr_d;
  logic [31:0] mem_din_q, mem_din_d;

  logic        accept;
  logic        reqFault;
  logic [3:0]  reqCause;
  logic        subWordStore;
  logic [31:0] loadData;
  logic [31:0] mergedWord;

  assign accept       = bus.req_valid && bus.req_ready;
  assign subWordStore = we_q && (funct3_q != F3_W);

  lsu_align u_align (
    .word_i   (bus.mem_dout),
    .lane_i   (adr_q[1:0]),
    .funct3_i (funct3_q),
    .wdata_i  (wdata_q),
    .rdata_o  (loadData),
    .merged_o (mergedWord)
  );

  // Fault priority: illegal funct3, then misalignment, then address range.
  always_comb begin
    reqFault = 1'b1;
    reqCause = '0;
    if (!funct3_legal(bus.req_we, bus.req_funct3)) begin
      reqCause = CAUSE_ILLEGAL;
    end else if (misaligned(bus.req_funct3, bus.req_adr[1:0])) begin
      reqCause = bus.req_we ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
    end else if ({bus.req_adr[31:2], 2'b00} > LAST_WORD) begin
      reqCause = bus.req_we ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
    end else begin
      reqFault = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      funct3_q    <= '0;
      adr_q       <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_trap_q  <= 1'b0;
      rsp_cause_q <= '0;
      rsp_tval_q  <= '0;
      mem_mrd_q   <= 1'b0;
      mem_mwr_q   <= 1'b0;
      mem_din_q   <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_trap_q  <= rsp_trap_d;
      rsp_cause_q <= rsp_cause_d;
      rsp_tval_q  <= rsp_tval_d;
      mem_mrd_q   <= mem_mrd_d;
      mem_mwr_q   <= mem_mwr_d;
      mem_din_q   <= mem_din_d;
      if (accept) begin
        we_q     <= bus.req_we;
        funct3_q <= bus.req_funct3;
        adr_q    <= bus.req_adr;
        wdata_q  <= bus.req_wdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = reqFault ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: state_d = subWordStore ? ST_WRITE : ST_RESP;
      ST_WRITE:  state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed for the state being entered and registered,
  // so each one is visible during that state's cycle.
  always_comb begin
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_trap_d  = 1'b0;
    rsp_cause_d = '0;
    rsp_tval_d  = '0;
    mem_mrd_d   = 1'b0;
    mem_mwr_d   = 1'b0;
    mem_din_d   = mem_din_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (reqFault) begin
            rsp_valid_d = 1'b1;
            rsp_trap_d  = 1'b1;
            rsp_cause_d = reqCause;
            rsp_tval_d  = bus.req_adr;
          end else if (bus.req_we && (bus.req_funct3 == F3_W)) begin
            mem_mwr_d = 1'b1;
            mem_din_d = bus.req_wdata;
          end else begin
            mem_mrd_d = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        if (!we_q) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = loadData;
        end else if (!subWordStore) begin
          rsp_valid_d = 1'b1;
        end else begin
          mem_mwr_d = 1'b1;
          mem_din_d = mergedWord;
        end
      end
      ST_WRITE: rsp_valid_d = 1'b1;
      default:  rsp_valid_d = 1'b0;
    endcase
  end

  // Forcing outputs low while rst is high keeps a pending RMW write off the reset edge.
  assign bus.req_ready = (state_q == ST_IDLE) && !rst;
  assign bus.rsp_valid = rst ? 1'b0 : rsp_valid_q;
  assign bus.rsp_rdata = rst ? '0   : rsp_rdata_q;
  assign bus.rsp_trap  = rst ? 1'b0 : rsp_trap_q;
  assign bus.rsp_cause = rst ? '0   : rsp_cause_q;
  assign bus.rsp_tval  = rst ? '0   : rsp_tval_q;
  assign bus.mem_mrd   = rst ? 1'b0 : mem_mrd_q;
  assign bus.mem_mwr   = rst ? 1'b0 : mem_mwr_q;
  assign bus.mem_adr   = rst ? '0   : {adr_q[31:2], 2'b00};
  assign bus.mem_din   = rst ? '0   : mem_din_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios plus random traffic,
// compared against a byte-array reference model of the RV32I load/store rules.
module tb_lsu_ctrl;

  localparam int MEMB = 65536;

  logic clk = 1'b0;
  logic rst;
  logic preload = 1'b0;

  lsu_ctrl_if bus ();

  lsu_ctrl #(.MEM_BYTES(MEMB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  logic [7:0] envMem [0:MEMB-1];
  logic [7:0] refMem [0:MEMB-1];

  int checks = 0;
  int errors = 0;
  int writeCount = 0;
  int bothCount = 0;
  logic [31:0] lastRdata;
  logic [3:0]  lastCause;

  // Data memory seen by the DUT: combinational read, full-word write on posedge.
  always_comb begin
    if (bus.mem_adr < 32'(MEMB)) begin
      bus.mem_dout = {envMem[bus.mem_adr[15:0] + 16'd3], envMem[bus.mem_adr[15:0] + 16'd2],
                      envMem[bus.mem_adr[15:0] + 16'd1], envMem[bus.mem_adr[15:0]]};
    end else begin
      bus.mem_dout = 32'h0;
    end
  end

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < MEMB; i++) envMem[i] <= refMem[i];
    end else if (bus.mem_mwr) begin
      if (bus.mem_adr < 32'(MEMB)) begin
        envMem[bus.mem_adr[15:0]]         <= bus.mem_din[7:0];
        envMem[bus.mem_adr[15:0] + 16'd1] <= bus.mem_din[15:8];
        envMem[bus.mem_adr[15:0] + 16'd2] <= bus.mem_din[23:16];
        envMem[bus.mem_adr[15:0] + 16'd3] <= bus.mem_din[31:24];
      end
      writeCount <= writeCount + 1;
    end
  end

  always @(negedge clk) begin
    if (bus.mem_mrd && bus.mem_mwr) bothCount <= bothCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic int accessBytes(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] refCause(input logic we, input logic [2:0] f3, input logic [31:0] adr);
    bit legal;
    legal = (f3 <= 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5));
    if (!legal) return 4'd2;
    if ((adr % 32'(accessBytes(f3))) != 0) return we ? 4'd6 : 4'd4;
    if ((adr & 32'hFFFF_FFFC) > 32'(MEMB - 4)) return we ? 4'd7 : 4'd5;
    return 4'd0;
  endfunction

  function automatic logic [31:0] refWord(input logic [31:0] adr);
    int base = int'(adr[15:0]);
    return {refMem[base + 3], refMem[base + 2], refMem[base + 1], refMem[base]};
  endfunction

  function automatic logic [31:0] envWord(input logic [31:0] adr);
    int base = int'(adr[15:0]);
    return {envMem[base + 3], envMem[base + 2], envMem[base + 1], envMem[base]};
  endfunction

  function automatic logic [31:0] refLoad(input logic [2:0] f3, input logic [31:0] adr);
    int n = accessBytes(f3);
    int base = int'(adr[15:0]);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(refMem[base + i]) << (8 * i));
    if ((f3 == 3'd0 || f3 == 3'd1) && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic refStore(input logic [2:0] f3, input logic [31:0] adr, input logic [31:0] wdata);
    int base = int'(adr[15:0]);
    for (int i = 0; i < accessBytes(f3); i++) refMem[base + i] = wdata[8 * i +: 8];
  endtask

  // One request from an idle controller through the cycle after its response.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] adr,
                               input logic [31:0] wdata);
    logic [3:0]  expCause;
    logic [31:0] expRdata = 32'h0;
    logic [31:0] expWord = 32'h0;
    int expLat, expRd, expWr;
    int lat = 0, rdCyc = 0, wrCyc = 0, wc0;
    logic [31:0] gotAdr = 32'h0, gotDin = 32'h0, gotRdata = 32'h0, gotTval = 32'h0;
    logic gotTrap = 1'b0;
    logic [3:0] gotCause = 4'h0;
    expCause = refCause(we, f3, adr);
    if (expCause != 0) begin
      expLat = 1; expRd = 0; expWr = 0;
    end else if (!we) begin
      expLat = 2; expRd = 1; expWr = 0; expRdata = refLoad(f3, adr);
    end else if (f3 == 3'd2) begin
      expLat = 2; expRd = 0; expWr = 1;
    end else begin
      expLat = 3; expRd = 1; expWr = 1;
    end
    @(negedge clk);
    checkOutput("ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_adr = adr; bus.req_wdata = wdata;
    wc0 = writeCount;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.req_valid = 1'b0; bus.req_we = 1'($urandom); bus.req_funct3 = 3'($urandom);
        bus.req_adr = $urandom; bus.req_wdata = $urandom;
      end
      if (bus.mem_mrd) begin rdCyc++; gotAdr = bus.mem_adr; end
      if (bus.mem_mwr) begin wrCyc++; gotAdr = bus.mem_adr; gotDin = bus.mem_din; end
      if (bus.rsp_valid) begin
        lat = k; gotRdata = bus.rsp_rdata; gotTrap = bus.rsp_trap;
        gotCause = bus.rsp_cause; gotTval = bus.rsp_tval;
      end
    end
    @(negedge clk);
    checkOutput("rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
    checkOutput("ready_after", 32'(bus.req_ready), 32'd1);
    if (expCause == 0 && we) begin
      refStore(f3, adr, wdata);
      expWord = refWord(adr & 32'hFFFF_FFFC);
    end
    checkOutput("latency", 32'(lat), 32'(expLat));
    checkOutput("trap", 32'(gotTrap), 32'(expCause != 0));
    checkOutput("cause", 32'(gotCause), 32'(expCause));
    checkOutput("tval", gotTval, (expCause != 0) ? adr : 32'h0);
    checkOutput("rdata", gotRdata, expRdata);
    checkOutput("mrd_cycles", 32'(rdCyc), 32'(expRd));
    checkOutput("mwr_cycles", 32'(wrCyc), 32'(expWr));
    if (expRd + expWr > 0) checkOutput("mem_adr", gotAdr, adr & 32'hFFFF_FFFC);
    if (expWr > 0) begin
      checkOutput("mem_din", gotDin, expWord);
      checkOutput("mem_word", envWord(adr & 32'hFFFF_FFFC), expWord);
      checkOutput("write_count", 32'(writeCount - wc0), 32'd1);
    end
    lastRdata = gotRdata;
    lastCause = gotCause;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acceptNext, issued, pulses, prevCyc, readyCycles, wc0, badWords;
    logic r, bigWe;
    logic [2:0] rf3;
    logic [31:0] radr;

    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_adr = 32'h0; bus.req_wdata = 32'h0;
    for (int i = 0; i < MEMB; i++) refMem[i] = 8'($urandom);
    refMem[16'h1000] = 8'hF3; refMem[16'h1001] = 8'h82;
    refMem[16'h1002] = 8'h81; refMem[16'h1003] = 8'h80;
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("rst_mrd", 32'(bus.mem_mrd), 32'd0);
    checkOutput("rst_mwr", 32'(bus.mem_mwr), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("post_rst_adr", bus.mem_adr, 32'h0);
    checkOutput("post_rst_din", bus.mem_din, 32'h0);

    applyStimulus(1'b0, 3'd0, 32'h1000, $urandom);
    checkOutput("LB_value", lastRdata, 32'hFFFF_FFF3);
    applyStimulus(1'b0, 3'd4, 32'h1001, $urandom);
    checkOutput("LBU_value", lastRdata, 32'h0000_0082);
    applyStimulus(1'b0, 3'd1, 32'h1002, $urandom);
    checkOutput("LH_value", lastRdata, 32'hFFFF_8081);
    applyStimulus(1'b0, 3'd2, 32'h1000, $urandom);
    checkOutput("LW_value", lastRdata, 32'h8081_82F3);
    applyStimulus(1'b1, 3'd0, 32'h1001, 32'h1234_56AA);
    checkOutput("SB_word", envWord(32'h1000), 32'h8081_AAF3);
    applyStimulus(1'b0, 3'd2, 32'h1000, $urandom);
    checkOutput("LW_after_SB", lastRdata, 32'h8081_AAF3);
    applyStimulus(1'b1, 3'd1, 32'h1002, 32'h0000_BEEF);
    checkOutput("SH_word", envWord(32'h1000), 32'hBEEF_AAF3);
    applyStimulus(1'b1, 3'd2, 32'h1004, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 3'd2, 32'h1004, $urandom);
    checkOutput("LW_after_SW", lastRdata, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 3'd2, 32'h1002, $urandom);
    checkOutput("LW_misaligned", 32'(lastCause), 32'd4);
    applyStimulus(1'b1, 3'd1, 32'h1003, $urandom);
    checkOutput("SH_misaligned", 32'(lastCause), 32'd6);
    applyStimulus(1'b0, 3'd2, 32'h0001_0000, $urandom);
    checkOutput("LW_range", 32'(lastCause), 32'd5);
    applyStimulus(1'b1, 3'd2, 32'h0000_FFFC, 32'hCAFE_F00D);
    checkOutput("SW_top_word", envWord(32'hFFFC), 32'hCAFE_F00D);
    applyStimulus(1'b0, 3'd3, 32'h1000, $urandom);
    checkOutput("illegal_f3", 32'(lastCause), 32'd2);
    applyStimulus(1'b1, 3'd2, 32'hFFFF_FFFC, $urandom);
    checkOutput("SW_wrap_range", 32'(lastCause), 32'd7);

    // Reset in the WRITE cycle of an SB must leave memory untouched.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'd0;
    bus.req_adr = 32'h1000; bus.req_wdata = 32'h0000_0055;
    @(negedge clk);
    bus.req_valid = 1'b0;
    checkOutput("rmw_read", 32'(bus.mem_mrd), 32'd1);
    @(negedge clk);
    checkOutput("rmw_write_pending", 32'(bus.mem_mwr), 32'd1);
    wc0 = writeCount;
    rst = 1'b1;
    #1;
    checkOutput("rmw_rst_mwr", 32'(bus.mem_mwr), 32'd0);
    checkOutput("rmw_rst_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("rmw_rst_din", bus.mem_din, 32'h0);
    checkOutput("rmw_rst_adr", bus.mem_adr, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rmw_ready_after", 32'(bus.req_ready), 32'd1);
    checkOutput("rmw_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("rmw_no_write", 32'(writeCount - wc0), 32'd0);
    checkOutput("rmw_word_kept", envWord(32'h1000), refWord(32'h1000));

    // Three loads with req_valid held high.
    @(negedge clk);
    issued = 0; pulses = 0; prevCyc = 0; readyCycles = 0;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'd2; bus.req_adr = 32'h1000;
    acceptNext = int'(bus.req_ready);
    if (acceptNext != 0) readyCycles++;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        checkOutput("b2b_rdata", bus.rsp_rdata, refLoad(3'd2, 32'h1000 + 32'(4 * pulses)));
        checkOutput("b2b_ready_busy", 32'(bus.req_ready), 32'd0);
        if (pulses > 0) checkOutput("b2b_gap", 32'(cyc - prevCyc), 32'd3);
        prevCyc = cyc;
        pulses++;
      end
      if (acceptNext != 0) begin
        issued++;
        if (issued == 3) bus.req_valid = 1'b0;
        else bus.req_adr = 32'h1000 + 32'(4 * issued);
      end
      acceptNext = int'(bus.req_valid && bus.req_ready);
      if (acceptNext != 0) readyCycles++;
    end
    checkOutput("b2b_pulses", 32'(pulses), 32'd3);
    checkOutput("b2b_ready_cycles", 32'(readyCycles), 32'd3);

    for (int n = 0; n < 200; n++) begin
      r = 1'b0;
      bigWe = 1'($urandom);
      rf3 = 3'($urandom);
      case ($urandom_range(0, 9))
        7:       radr = 32'h0000_FFF0 + 32'($urandom_range(0, 15));
        8:       radr = 32'h0001_0000 + 32'($urandom_range(0, 15));
        9:       radr = $urandom;
        default: radr = 32'h1000 + 32'($urandom_range(0, 63));
      endcase
      if (r) rf3 = 3'd0;
      applyStimulus(bigWe, rf3, radr, $urandom);
    end

    badWords = 0;
    for (int a = 32'h1000; a < 32'h1044; a += 4) begin
      if (envWord(32'(a)) !== refWord(32'(a))) badWords++;
    end
    checkOutput("final_mem_sweep", 32'(badWords), 32'd0);
    checkOutput("mrd_mwr_exclusive", 32'(bothCount), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store controller between the RV32I core's memory stage and the byte-addressed, little-endian, word-wide data memory.
- Memory has a combinational read, writes all 4 bytes at the clk posedge and has no byte enables.
- The block decodes funct3 size/sign, checks alignment and range, and returns sign/zero-extended load data.
- Sub-word stores are done as read-modify-write; faults are reported to the trap unit as cause/tval.

Parameters:
- MEM_BYTES, 65536, data memory size in bytes; an aligned word address above MEM_BYTES-4 is an access fault.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  core request valid.
- req_ready  out  1  high only in IDLE and not rst; a request is accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 size/sign code.
- req_adr  in  32  byte address.
- req_wdata  in  32  store data; low byte or half is used for SB/SH.
- rsp_valid  out  1  one-cycle pulse; completion.
- rsp_rdata  out  32  extended load data; 0 for stores and traps.
- rsp_trap  out  1  request faulted; valid with rsp_valid.
- rsp_cause  out  4  mcause: 2 illegal funct3, 4 load misaligned, 5 load access fault, 6 store misaligned, 7 store access fault.
- rsp_tval  out  32  faulting address (req_adr); 0 if no trap.
- mem_mrd  out  1  memory read enable.
- mem_mwr  out  1  memory write enable.
- mem_adr  out  32  word-aligned address, always {req_adr[31:2],2'b00}.
- mem_din  out  32  write word.
- mem_dout  in  32  combinational read word.

Behaviour:
- Reset: state=IDLE. req_ready=0 while rst. All other outputs =0 (rsp_*, mem_mrd, mem_mwr, mem_adr, mem_din). Request latches are cleared.
- States are IDLE, ACCESS, WRITE and RESP; all outputs are registered except req_ready.
- IDLE, on accept:
  - Latch we, funct3, adr and wdata.
  - Check order: illegal funct3, then misaligned, then range.
  - Legal loads: 0,1,2,4,5. Legal stores: 0,1,2.
  - Misaligned: half with adr[0]=1, or word with adr[1:0]!=0.
  - Range fault: aligned address > MEM_BYTES-4.
  - Any fault goes to RESP with trap set and no memory access. Otherwise go to ACCESS.
- ACCESS, load or sub-word store:
  - mem_mrd=1.
  - Load: extract the lane by adr[1:0], sign-extend for funct3 0/1 and zero-extend for 4/5, into rsp_rdata; go to RESP.
  - Sub-word store: merge the byte/half into mem_dout at lane adr[1:0] and register it as mem_din; go to WRITE.
- ACCESS, SW: mem_mwr=1, mem_din=wdata; memory writes at the cycle-end edge; go to RESP.
- WRITE: mem_mwr=1 with the merged word; go to RESP.
- RESP: rsp_valid=1 for exactly one cycle; go to IDLE.
- Latency from accept edge to rsp_valid high:
  - trap: 1 cycle.
  - load / SW: 2 cycles.
  - SB/SH: 3 cycles.
  - A new request is accepted on the edge after the RESP cycle, so the minimum spacing is (latency + 1) cycles.
- mem_mrd and mem_mwr are never both 1. Both are 0 in IDLE and RESP.
- Memory control outputs are gated so no write occurs on any edge where rst=1. Reset during WRITE aborts the RMW and memory is unchanged.
- Request inputs are ignored outside IDLE. Inputs are sampled only at accept; later changes have no effect.
- Address wrap is not checked beyond the range rule; adr 0xFFFFFFFC is a range fault.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants: F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5.
  - cause constants: 2, 4, 5, 6, 7.
  - state encoding.
- Sub-module lsu_align is combinational and shared by load extraction and store merge. It provides:
  - load extract: word, adr[1:0], funct3 -> rdata.
  - store merge: old word, wdata, adr[1:0], funct3 -> new word.

Test Plan:
- Preload mem[0x1000..0x1003]=F3,82,81,80 (word 0x808182F3). Loads, each giving rsp_valid 2 cycles after accept with mem_adr=0x1000 and trap=0:
  - LB 0x1000 -> rsp_rdata 0xFFFFFFF3.
  - LBU 0x1001 -> 0x00000082.
  - LH 0x1002 -> 0xFFFF8081.
  - LW 0x1000 -> 0x808182F3.
- SB 0x1001 wdata 0x123456AA -> mem_mrd in cycle 1, mem_mwr in cycle 2 with mem_din 0x8081AAF3, rsp_valid in cycle 3. A following LW 0x1000 returns 0x8081AAF3.
- SH 0x1002 wdata 0xBEEF -> word 0xBEEFAAF3. SW 0x1004 0xDEADBEEF -> mwr in cycle 1, single write; LW 0x1004 returns 0xDEADBEEF.
- Fault cases, each: rsp_valid 1 cycle after accept, mem_mrd/mem_mwr never asserted.
  - LW 0x1002 -> trap=1, cause 4, tval 0x1002.
  - SH 0x1003 -> cause 6.
  - LW 0x10000 (MEM_BYTES=65536) -> cause 5.
  - SW 0xFFFC -> succeeds.
  - funct3=3 load -> cause 2.
- SB 0x1000 with rst asserted in the WRITE cycle -> no mem_mwr, memory word unchanged, all outputs 0, req_ready=1 on the first cycle after rst drops.
- Back-to-back: req_valid held high with 3 loads -> req_ready low while busy; exactly 3 rsp_valid pulses, 3 cycles apart.
